// File: rtl/decode_stage.sv
// RV32 decode stage: combinational decode at the input, result held in a
// 2-entry skid FIFO whose head drives all out_* ports.
module decode_stage #(
   parameter int unsigned PC_W         = 32,
   parameter bit          ENABLE_M     = 1'b1,
   parameter bit          ENABLE_ZICSR = 1'b1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush_in,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [PC_W-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [PC_W-1:0] out_pc,
   output logic [3:0]      out_class,
   output logic [4:0]      out_rd,
   output logic [4:0]      out_rs1,
   output logic [4:0]      out_rs2,
   output logic [2:0]      out_funct3,
   output logic            out_alt,
   output logic [31:0]     out_imm,
   output logic            out_rd_we,
   output logic            out_illegal
);

   localparam logic [3:0] C_LUI    = 4'd0;
   localparam logic [3:0] C_AUIPC  = 4'd1;
   localparam logic [3:0] C_JAL    = 4'd2;
   localparam logic [3:0] C_JALR   = 4'd3;
   localparam logic [3:0] C_BRANCH = 4'd4;
   localparam logic [3:0] C_LOAD   = 4'd5;
   localparam logic [3:0] C_STORE  = 4'd6;
   localparam logic [3:0] C_OPIMM  = 4'd7;
   localparam logic [3:0] C_OP     = 4'd8;
   localparam logic [3:0] C_MULDIV = 4'd9;
   localparam logic [3:0] C_FENCE  = 4'd10;
   localparam logic [3:0] C_SYSTEM = 4'd11;
   localparam logic [3:0] C_ILL    = 4'd15;

   typedef struct packed {
      logic [PC_W-1:0] pc;
      logic [3:0]      cls;
      logic [4:0]      rd;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [2:0]      funct3;
      logic            alt;
      logic [31:0]     imm;
      logic            rd_we;
      logic            illegal;
   } entry_t;

   entry_t     dec, e0, e1;
   logic [1:0] cnt;
   logic       push, pop;

   logic [6:0] opcode, funct7;
   logic [2:0] f3;
   logic       ill, we;

   assign opcode = in_instr[6:0];
   assign funct7 = in_instr[31:25];
   assign f3     = in_instr[14:12];

   always_comb begin
      dec        = '0;
      ill        = 1'b0;
      we         = 1'b0;
      dec.pc     = in_pc;
      dec.rd     = in_instr[11:7];
      dec.rs1    = in_instr[19:15];
      dec.rs2    = in_instr[24:20];
      dec.funct3 = f3;
      if (opcode[1:0] != 2'b11) begin
         ill = 1'b1;
      end else begin
         case (opcode)
            7'b0110111: begin dec.cls = C_LUI;   we = 1'b1; dec.imm = {in_instr[31:12], 12'h000}; end
            7'b0010111: begin dec.cls = C_AUIPC; we = 1'b1; dec.imm = {in_instr[31:12], 12'h000}; end
            7'b1101111: begin
               dec.cls = C_JAL; we = 1'b1;
               dec.imm = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b1100111: begin
               dec.cls = C_JALR; we = 1'b1; ill = (f3 != 3'd0);
               dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b1100011: begin
               dec.cls = C_BRANCH; ill = (f3 == 3'd2) || (f3 == 3'd3);
               dec.imm = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0000011: begin
               dec.cls = C_LOAD; we = 1'b1; ill = (f3 == 3'd3) || (f3 >= 3'd6);
               dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b0100011: begin
               dec.cls = C_STORE; ill = (f3 > 3'd2);
               dec.imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b0010011: begin
               dec.cls = C_OPIMM; we = 1'b1;
               dec.imm = {{20{in_instr[31]}}, in_instr[31:20]};
               if (f3 == 3'd1) ill = (funct7 != 7'h00);
               if (f3 == 3'd5) begin
                  ill     = (funct7 != 7'h00) && (funct7 != 7'h20);
                  dec.alt = in_instr[30];
               end
            end
            7'b0110011: begin
               we = 1'b1;
               if (funct7 == 7'h01) begin
                  dec.cls = C_MULDIV; ill = !ENABLE_M;
               end else begin
                  dec.cls = C_OP;
                  dec.alt = in_instr[30];
                  ill = !((funct7 == 7'h00) ||
                          ((funct7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5))));
               end
            end
            7'b0001111: dec.cls = C_FENCE;
            7'b1110011: begin
               dec.cls = C_SYSTEM;
               dec.imm = {20'h00000, in_instr[31:20]};
               if (f3 != 3'd0) begin
                  we  = 1'b1;
                  ill = !ENABLE_ZICSR;
               end
            end
            default: ill = 1'b1;
         endcase
      end
      // Illegal entries keep their raw register fields but carry no side effects.
      if (ill) begin
         dec.cls = C_ILL;
         dec.imm = '0;
         dec.alt = 1'b0;
         we      = 1'b0;
      end
      dec.illegal = ill;
      dec.rd_we   = we && (dec.rd != 5'd0);
   end

   assign in_ready  = (cnt != 2'd2) && !rst;
   assign out_valid = (cnt != 2'd0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst || flush_in) begin
         cnt <= '0;
         e0  <= '0;
         e1  <= '0;
      end else begin
         case ({push, pop})
            2'b11: begin
               if (cnt == 2'd2) begin
                  e0 <= e1;
                  e1 <= dec;
               end else begin
                  e0 <= dec;
               end
            end
            2'b01: begin
               e0  <= e1;
               cnt <= cnt - 2'd1;
            end
            2'b10: begin
               if (cnt == 2'd0) e0 <= dec;
               else             e1 <= dec;
               cnt <= cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign out_pc      = e0.pc;
   assign out_class   = e0.cls;
   assign out_rd      = e0.rd;
   assign out_rs1     = e0.rs1;
   assign out_rs2     = e0.rs2;
   assign out_funct3  = e0.funct3;
   assign out_alt     = e0.alt;
   assign out_imm     = e0.imm;
   assign out_rd_we   = e0.rd_we;
   assign out_illegal = e0.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: full-feature instance plus an instance
// with M and Zicsr disabled sharing the same input stimulus.
module tb_decode_stage;

   logic        clk = 1'b0;
   logic        rst, flush_in, in_valid, out_ready;
   logic [31:0] in_instr, in_pc;

   logic        in_ready, out_valid, out_alt, out_rd_we, out_illegal;
   logic [31:0] out_pc, out_imm;
   logic [3:0]  out_class;
   logic [4:0]  out_rd, out_rs1, out_rs2;
   logic [2:0]  out_funct3;

   logic        n_in_ready, n_out_valid, n_out_alt, n_out_rd_we, n_out_illegal;
   logic [31:0] n_out_pc, n_out_imm;
   logic [3:0]  n_out_class;
   logic [4:0]  n_out_rd, n_out_rs1, n_out_rs2;
   logic [2:0]  n_out_funct3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   decode_stage #(.PC_W(32), .ENABLE_M(1'b1), .ENABLE_ZICSR(1'b1)) dut (
      .clk(clk), .rst(rst), .flush_in(flush_in),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .out_class(out_class), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_funct3(out_funct3), .out_alt(out_alt), .out_imm(out_imm),
      .out_rd_we(out_rd_we), .out_illegal(out_illegal)
   );

   decode_stage #(.PC_W(32), .ENABLE_M(1'b0), .ENABLE_ZICSR(1'b0)) dut_nom (
      .clk(clk), .rst(rst), .flush_in(flush_in),
      .in_valid(in_valid), .in_ready(n_in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(n_out_valid), .out_ready(out_ready), .out_pc(n_out_pc),
      .out_class(n_out_class), .out_rd(n_out_rd), .out_rs1(n_out_rs1), .out_rs2(n_out_rs2),
      .out_funct3(n_out_funct3), .out_alt(n_out_alt), .out_imm(n_out_imm),
      .out_rd_we(n_out_rd_we), .out_illegal(n_out_illegal)
   );

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  cls;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic        we;
      logic        ill;
      logic        alt;
      logic [3:0]  cls_nom;
   } vec_t;

   localparam int NV = 20;
   vec_t vecs[NV];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{32'h00500093, 4'd7,  5'd1,  32'h00000005, 1'b1, 1'b0, 1'b0, 4'd7};
      vecs[1]  = '{32'hFE000EE3, 4'd4,  5'd29, 32'hFFFFFFFC, 1'b0, 1'b0, 1'b0, 4'd4};
      vecs[2]  = '{32'h123450B7, 4'd0,  5'd1,  32'h12345000, 1'b1, 1'b0, 1'b0, 4'd0};
      vecs[3]  = '{32'h407302B3, 4'd8,  5'd5,  32'h00000000, 1'b1, 1'b0, 1'b1, 4'd8};
      vecs[4]  = '{32'hFE20AC23, 4'd6,  5'd24, 32'hFFFFFFF8, 1'b0, 1'b0, 1'b0, 4'd6};
      vecs[5]  = '{32'h001000EF, 4'd2,  5'd1,  32'h00000800, 1'b1, 1'b0, 1'b0, 4'd2};
      vecs[6]  = '{32'hFFFFF06F, 4'd2,  5'd0,  32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 4'd2};
      vecs[7]  = '{32'h40315093, 4'd7,  5'd1,  32'h00000403, 1'b1, 1'b0, 1'b1, 4'd7};
      vecs[8]  = '{32'h40311093, 4'd15, 5'd1,  32'h00000000, 1'b0, 1'b1, 1'b0, 4'd15};
      vecs[9]  = '{32'h00000000, 4'd15, 5'd0,  32'h00000000, 1'b0, 1'b1, 1'b0, 4'd15};
      vecs[10] = '{32'h00003083, 4'd15, 5'd1,  32'h00000000, 1'b0, 1'b1, 1'b0, 4'd15};
      vecs[11] = '{32'h305110F3, 4'd11, 5'd1,  32'h00000305, 1'b1, 1'b0, 1'b0, 4'd15};
      vecs[12] = '{32'h00000073, 4'd11, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0, 4'd11};
      vecs[13] = '{32'hFFF12083, 4'd5,  5'd1,  32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 4'd5};
      vecs[14] = '{32'h000010E7, 4'd15, 5'd1,  32'h00000000, 1'b0, 1'b1, 1'b0, 4'd15};
      vecs[15] = '{32'h0FF0000F, 4'd10, 5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0, 4'd10};
      vecs[16] = '{32'hFFFFF117, 4'd1,  5'd2,  32'hFFFFF000, 1'b1, 1'b0, 1'b0, 4'd1};
      vecs[17] = '{32'h022081B3, 4'd9,  5'd3,  32'h00000000, 1'b1, 1'b0, 1'b0, 4'd15};
      vecs[18] = '{32'h400010B3, 4'd15, 5'd1,  32'h00000000, 1'b0, 1'b1, 1'b0, 4'd15};
      vecs[19] = '{32'h00002063, 4'd15, 5'd0,  32'h00000000, 1'b0, 1'b1, 1'b0, 4'd15};

      rst = 1'b1; flush_in = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      in_instr = 32'h00500093; in_pc = 32'h0;

      // Reset
      step();
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      check("rst_out_imm", out_imm, 32'd0);
      check("rst_out_class", {28'd0, out_class}, 32'd0);
      in_valid = 1'b0; rst = 1'b0;
      #1;
      check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Single addi, latency 1
      in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h100;
      step();
      in_valid = 1'b0;
      check("addi_valid", {31'd0, out_valid}, 32'd1);
      check("addi_class", {28'd0, out_class}, 32'd7);
      check("addi_rd", {27'd0, out_rd}, 32'd1);
      check("addi_rs1", {27'd0, out_rs1}, 32'd0);
      check("addi_imm", out_imm, 32'd5);
      check("addi_we", {31'd0, out_rd_we}, 32'd1);
      check("addi_pc", out_pc, 32'h100);
      step();
      check("addi_drained", {31'd0, out_valid}, 32'd0);

      // mul with and without M
      in_valid = 1'b1; in_instr = 32'h022081B3; in_pc = 32'h104;
      step();
      in_valid = 1'b0;
      check("mul_class", {28'd0, out_class}, 32'd9);
      check("mul_rd", {27'd0, out_rd}, 32'd3);
      check("mul_rs1", {27'd0, out_rs1}, 32'd1);
      check("mul_rs2", {27'd0, out_rs2}, 32'd2);
      check("mul_we", {31'd0, out_rd_we}, 32'd1);
      check("nom_mul_class", {28'd0, n_out_class}, 32'd15);
      check("nom_mul_ill", {31'd0, n_out_illegal}, 32'd1);
      check("nom_mul_we", {31'd0, n_out_rd_we}, 32'd0);
      step();

      // Back-to-back stream, one output per cycle
      for (int i = 0; i <= NV; i++) begin
         if (i > 0) begin
            check($sformatf("v%0d_valid", i-1), {31'd0, out_valid}, 32'd1);
            check($sformatf("v%0d_pc", i-1), out_pc, 32'h1000 + 32'(4*(i-1)));
            check($sformatf("v%0d_cls", i-1), {28'd0, out_class}, {28'd0, vecs[i-1].cls});
            check($sformatf("v%0d_rd", i-1), {27'd0, out_rd}, {27'd0, vecs[i-1].rd});
            check($sformatf("v%0d_imm", i-1), out_imm, vecs[i-1].imm);
            check($sformatf("v%0d_we", i-1), {31'd0, out_rd_we}, {31'd0, vecs[i-1].we});
            check($sformatf("v%0d_ill", i-1), {31'd0, out_illegal}, {31'd0, vecs[i-1].ill});
            check($sformatf("v%0d_alt", i-1), {31'd0, out_alt}, {31'd0, vecs[i-1].alt});
            check($sformatf("v%0d_nom_cls", i-1), {28'd0, n_out_class}, {28'd0, vecs[i-1].cls_nom});
            check($sformatf("v%0d_nom_ill", i-1), {31'd0, n_out_illegal},
                  {31'd0, (vecs[i-1].cls_nom == 4'd15)});
         end
         if (i < NV) begin
            in_valid = 1'b1; in_instr = vecs[i].instr; in_pc = 32'h1000 + 32'(4*i);
            check($sformatf("b2b_rdy%0d", i), {31'd0, in_ready}, 32'd1);
         end else begin
            in_valid = 1'b0;
         end
         step();
      end
      check("b2b_drained", {31'd0, out_valid}, 32'd0);

      // Stall: A, B buffered, C held off until space frees
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h200;
      check("stall_rdyA", {31'd0, in_ready}, 32'd1);
      step();
      check("stall_A_head", out_pc, 32'h200);
      in_instr = 32'hFE000EE3; in_pc = 32'h204;
      check("stall_rdyB", {31'd0, in_ready}, 32'd1);
      step();
      in_instr = 32'h123450B7; in_pc = 32'h208;
      check("stall_rdyC", {31'd0, in_ready}, 32'd0);
      check("stall_A_pc1", out_pc, 32'h200);
      step();
      check("stall_A_pc2", out_pc, 32'h200);
      check("stall_A_cls", {28'd0, out_class}, 32'd7);
      check("stall_A_imm", out_imm, 32'd5);
      check("stall_full", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      step();
      check("stall_B_pc", out_pc, 32'h204);
      check("stall_B_cls", {28'd0, out_class}, 32'd4);
      check("stall_rdy_after", {31'd0, in_ready}, 32'd1);
      step();
      in_valid = 1'b0;
      check("stall_C_pc", out_pc, 32'h208);
      check("stall_C_cls", {28'd0, out_class}, 32'd0);
      step();
      check("stall_drained", {31'd0, out_valid}, 32'd0);

      // Flush with two buffered and one incoming
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_pc = 32'h300;
      step();
      in_pc = 32'h304;
      step();
      flush_in = 1'b1; in_pc = 32'h308;
      step();
      flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      check("flush_valid", {31'd0, out_valid}, 32'd0);
      check("flush_rdy", {31'd0, in_ready}, 32'd1);
      step();
      check("flush_stays_empty", {31'd0, out_valid}, 32'd0);

      // Flush together with pop
      in_valid = 1'b1; in_pc = 32'h400;
      step();
      in_valid = 1'b0; flush_in = 1'b1;
      check("flpop_pre", {31'd0, out_valid}, 32'd1);
      step();
      flush_in = 1'b0;
      check("flpop_valid", {31'd0, out_valid}, 32'd0);

      // Reset mid-stream
      out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'hFFF12083; in_pc = 32'h500;
      step();
      step();
      rst = 1'b1;
      #1;
      check("mrst_in_ready", {31'd0, in_ready}, 32'd0);
      step();
      rst = 1'b0; in_valid = 1'b0;
      check("mrst_valid", {31'd0, out_valid}, 32'd0);
      check("mrst_pc", out_pc, 32'd0);
      check("mrst_imm", out_imm, 32'd0);
      #1;
      check("mrst_rdy", {31'd0, in_ready}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Parameters
REQ-001 SHALL provide the following parameters, one per line:
- PC_W, 32, width of the program counter carried alongside each instruction.
- ENABLE_M, 1, decode RV32M multiply/divide; when 0, M encodings are illegal.
- ENABLE_ZICSR, 1, decode CSR instructions; when 0, SYSTEM funct3!=0 is illegal.

Interface
REQ-002 SHALL have one clock and a synchronous, active-high reset; port list (name, direction, width, meaning):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- flush_in  in  1  discard all buffered and incoming instructions
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_instr  in  32  raw RV32 instruction
- in_pc  in  PC_W  instruction address
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts
- out_pc  out  PC_W  pc of entry
- out_class  out  4  0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OPIMM, 8 OP, 9 MULDIV, 10 FENCE, 11 SYSTEM, 15 ILLEGAL
- out_rd, out_rs1, out_rs2  out  5 each  register indices
- out_funct3  out  3  instr[14:12]
- out_alt  out  1  instr[30] for OP/SRAI, else 0
- out_imm  out  32  sign-extended immediate
- out_rd_we  out  1  writes rd
- out_illegal  out  1  illegal encoding

Function
REQ-003 SHALL decode combinationally at input and register result into a 2-entry FIFO (skid buffer); outputs come from FIFO head only.
REQ-004 SHALL accept on in_valid&&in_ready; in_ready = (occupancy<2) && !rst, from registered state only (no combinational path from out_ready).
REQ-005 SHALL present an accepted instruction on out_valid the cycle after acceptance (latency 1) when FIFO was empty or head popped that cycle.
REQ-006 SHALL pop head on out_valid&&out_ready; simultaneous push and pop SHALL leave occupancy unchanged; sustained throughput 1/cycle.
REQ-007 SHALL hold all out_* stable while out_valid&&!out_ready; order SHALL be preserved.
REQ-008 Immediate per type: I = sext(instr[31:20]); S = sext({[31:25],[11:7]}); B = sext({[31],[7],[30:25],[11:8],0}); U = {[31:12],12'h0}; J = sext({[31],[19:12],[20],[30:21],0}); OP/MULDIV/FENCE/ILLEGAL imm = 0; SYSTEM imm = zero-extended [31:20].
REQ-009 Illegal when: instr[1:0]!=2'b11; unknown opcode; JALR funct3!=0; BRANCH funct3 in {2,3}; LOAD funct3 in {3,6,7}; STORE funct3>2; OPIMM shift with bad funct7; OP funct7 not in {0x00, 0x20 (ADD/SUB, SRL/SRA only)}; funct7=0x01 with ENABLE_M=0; SYSTEM rule per REQ-001.
REQ-010 Illegal entries SHALL still flow through with out_class=15, out_illegal=1, out_rd_we=0, out_imm=0.
REQ-011 out_rd_we=1 only for LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP, MULDIV, SYSTEM-CSR, and only when rd!=0.
REQ-012 flush_in SHALL clear both entries at the edge; an input presented in the flush cycle SHALL be dropped; out_valid=0 and in_ready=1 the following cycle.
REQ-013 Flush and pop in same cycle SHALL behave as flush.

Reset
REQ-014 While rst=1: in_ready=0; after the edge: out_valid=0, occupancy 0, all out_* data fields 0, in_ready=1 the cycle after rst deasserts.
REQ-015 rst mid-stream SHALL discard all buffered entries with no partial output.

Verification
REQ-016 Push 0x00500093 (addi x1,x0,5), pc 0x100, out_ready=1 -> next cycle out_valid=1, class=7, rd=1, rs1=0, imm=5, rd_we=1, pc=0x100.
REQ-017 Push 0xFE000EE3 (beq x0,x0,-4) -> class=4, imm=0xFFFFFFFC, rd_we=0, illegal=0.
REQ-018 ENABLE_M=0, push 0x022081B3 (mul x3,x1,x2) -> class=15, illegal=1, rd_we=0; ENABLE_M=1 -> class=9, rd=3, rs1=1, rs2=2, rd_we=1.
REQ-019 out_ready=0, in_valid=1 for 3 cycles with A,B,C -> A,B accepted, in_ready=0 in cycle 3; release out_ready -> A then B then C, no loss/duplication, outputs stable while stalled.
REQ-020 Two entries buffered, flush_in=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, the flushed and incoming entries never appear.
REQ-021 Back-to-back 16 pushes with out_ready=1 -> 16 outputs on consecutive cycles, in_ready never low.
